miniled_scan_driver: RTL and testbench
======================================

// Module: miniled_scan_driver
// PURPOSE
// Parametrised MiniLED constant-current driver interface: fetches per-channel gray words, shifts them
// out serially (SDI/DCLK), latches them (LE), then drives a GCLK burst while one scan line is active.
// Generalises the fixed 4-scan SPI7001 path in channel count, gray depth, scan lines, clock rate and
// scan polarity; adds blanking, input-stall handling and queued frame restarts.
// Sits between the backlight frame buffer (upstream, word handshake) and the LED board pins.
// PARAMETERS
// CHANNELS      16  gray words per scan line (daisy-chain length)
// GRAY_BITS     16  bits per gray word, shifted MSB first
// SCAN_LINES    4   scan outputs / lines per frame (>=2)
// CLK_DIV       2   I_clk cycles per DCLK/GCLK half-period (>=1)
// LE_DCLKS      1   LE high width, in DCLK periods
// GCLK_PULSES   4096 GCLK pulses per line display window
// BLANK_CYCLES  8   I_clk cycles all scans off between lines (>=1)
// SCAN_ACT_LOW  1   1: active scan line driven 0, others 1
// PORTS
// I_clk         in   1   system clock
// I_rst         in   1   async reset, active high
// I_frame_start in   1   1-cycle pulse: start a frame
// I_data        in   GRAY_BITS  gray word for O_line_idx/O_chan_idx
// I_data_valid  in   1   I_data valid
// O_data_ready  out  1   driver accepts word this cycle
// O_line_idx    out  clog2(SCAN_LINES) line being loaded
// O_chan_idx    out  clog2(CHANNELS) channel being requested
// SDI           out  1   serial gray data
// DCLK          out  1   shift clock
// LE            out  1   latch enable
// GCLK          out  1   PWM gray clock
// O_scan        out  SCAN_LINES  scan line drives
// O_busy        out  1   frame in progress
// O_frame_done  out  1   1-cycle pulse after last line's blank
// BEHAVIOUR
// Reset (async, immediate, any state): SDI/DCLK/LE/GCLK=0, O_scan all inactive, O_data_ready=0,
//   O_busy=0, O_frame_done=0, indices=0, pending-start=0, state IDLE.
// States: IDLE -> LOAD -> SHIFT -> (LOAD | LATCH) -> DISPLAY -> BLANK -> (LOAD | DONE) -> IDLE.
// IDLE: on I_frame_start or pending-start: line=0, chan=CHANNELS-1, O_busy=1, go LOAD.
// LOAD: O_data_ready=1; on valid&ready capture word into shift reg, ready drops next cycle, go SHIFT.
//   valid low: stay in LOAD, DCLK held 0, no timeout (stall).
// SHIFT: SDI=current bit (MSB first) at state entry; DCLK low CLK_DIV clks then high CLK_DIV clks;
//   SDI updates only while DCLK low; bit period 2*CLK_DIV clks; GRAY_BITS bits per word.
//   Last bit done: chan>0 -> chan-1, LOAD; chan==0 -> LATCH. Channels go out CHANNELS-1 first.
// LATCH: DCLK=0, SDI=0, LE=1 for LE_DCLKS*2*CLK_DIV clks, then DISPLAY.
// DISPLAY: O_scan[line] active; GCLK toggles every CLK_DIV clks, exactly GCLK_PULSES rising edges;
//   ends with GCLK=0, go BLANK.
// BLANK: all scans inactive BLANK_CYCLES clks; line<SCAN_LINES-1 -> line+1, chan=CHANNELS-1, LOAD;
//   else DONE: O_frame_done=1 one cycle, O_busy=0, IDLE.
// I_frame_start while O_busy: sets pending-start (single level, repeats merge); frame restarts the
//   cycle after O_frame_done. Start arriving same cycle as DONE counts as pending.
// Never two scan lines active; LE never high while DCLK or GCLK high.
// Counters sized clog2(max+1); no wrap inside a line; indices wrap to 0/CHANNELS-1 only per rules above.
// TESTING (CHANNELS=2, GRAY_BITS=4, SCAN_LINES=2, CLK_DIV=1, LE_DCLKS=1, GCLK_PULSES=4, BLANK_CYCLES=3)
// Reset mid-DISPLAY -> next cycle O_scan=2'b11, GCLK=0, O_busy=0; no activity until I_frame_start.
// Frame, words always valid: ch1=0xA, ch0=0x5 -> SDI on DCLK rises 1,0,1,0,0,1,0,1; LE high 2 clks.
// Line timing -> O_scan 2'b10 for exactly 4 GCLK rises, 3 clks 2'b11, then line 1 load; O_frame_done once.
// Stall: hold I_data_valid low 10 clks in LOAD -> DCLK stays 0, SDI unchanged, resumes cleanly.
// I_frame_start x3 during busy frame -> exactly one extra frame after O_frame_done, then IDLE.
// Checker throughout: one-hot-or-none scan, LE/DCLK/GCLK exclusivity, SDI stable while DCLK high.

Source files
------------

// File: rtl/miniled_scan_driver.sv
// MiniLED constant-current driver front end: fetches gray words per scan line, shifts them out on
// SDI/DCLK, latches with LE, then runs a GCLK burst with that line's scan output active.
module miniled_scan_driver #(
    parameter int CHANNELS     = 16,
    parameter int GRAY_BITS    = 16,
    parameter int SCAN_LINES   = 4,
    parameter int CLK_DIV      = 2,
    parameter int LE_DCLKS     = 1,
    parameter int GCLK_PULSES  = 4096,
    parameter int BLANK_CYCLES = 8,
    parameter int SCAN_ACT_LOW = 1
) (
    input  logic                                          I_clk,
    input  logic                                          I_rst,
    input  logic                                          I_frame_start,
    input  logic [GRAY_BITS-1:0]                          I_data,
    input  logic                                          I_data_valid,
    output logic                                          O_data_ready,
    output logic [$clog2(SCAN_LINES)-1:0]                 O_line_idx,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] O_chan_idx,
    output logic                                          SDI,
    output logic                                          DCLK,
    output logic                                          LE,
    output logic                                          GCLK,
    output logic [SCAN_LINES-1:0]                         O_scan,
    output logic                                          O_busy,
    output logic                                          O_frame_done
);

    localparam int LW     = $clog2(SCAN_LINES);
    localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DW     = $clog2(CLK_DIV + 1);
    localparam int BW     = $clog2(GRAY_BITS + 1);
    localparam int LE_LEN = LE_DCLKS * 2 * CLK_DIV;
    localparam int EW     = $clog2(LE_LEN + 1);
    localparam int PW     = $clog2(GCLK_PULSES + 1);
    localparam int KW     = $clog2(BLANK_CYCLES + 1);

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(GRAY_BITS - 1);
    localparam logic [EW-1:0] LE_LAST    = EW'(LE_LEN - 1);
    localparam logic [PW-1:0] PULSE_MAX  = PW'(GCLK_PULSES);
    localparam logic [KW-1:0] BLANK_LAST = KW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] CHAN_LAST  = CW'(CHANNELS - 1);
    localparam logic [LW-1:0] LINE_LAST  = LW'(SCAN_LINES - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, SHIFT, LATCH, DISPLAY, BLANK, DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          line_q;
    logic [CW-1:0]          chan_q;
    logic [GRAY_BITS-1:0]   shreg;
    logic [DW-1:0]          div_q;
    logic [BW-1:0]          bit_q;
    logic [EW-1:0]          le_q;
    logic [PW-1:0]          pulse_q;
    logic [KW-1:0]          blank_q;
    logic                   dclk_q, gclk_q, pending_q;
    logic                   div_end, shift_fall, word_end, le_end, disp_end, blank_end;
    logic                   start_req, active;
    logic [SCAN_LINES-1:0]  scan_on;

    assign div_end    = (div_q == DIV_LAST);
    assign shift_fall = (state_q == SHIFT) && dclk_q && div_end;
    assign word_end   = shift_fall && (bit_q == BIT_LAST);
    assign le_end     = (le_q == LE_LAST);
    assign disp_end   = (state_q == DISPLAY) && gclk_q && div_end && (pulse_q == PULSE_MAX);
    assign blank_end  = (blank_q == BLANK_LAST);
    assign start_req  = I_frame_start || pending_q;
    assign active     = (state_q == LOAD) || (state_q == SHIFT) || (state_q == LATCH) ||
                        (state_q == DISPLAY) || (state_q == BLANK);

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        O_data_ready = 1'b0;
        O_busy       = active;
        O_frame_done = 1'b0;
        LE           = 1'b0;
        SDI          = 1'b0;
        scan_on      = '0;
        case (state_q)
            IDLE:    if (start_req) state_d = LOAD;
            LOAD: begin
                O_data_ready = 1'b1;
                if (I_data_valid) state_d = SHIFT;
            end
            SHIFT: begin
                SDI = shreg[GRAY_BITS-1];
                if (word_end) state_d = (chan_q != '0) ? LOAD : LATCH;
            end
            LATCH: begin
                LE = 1'b1;
                if (le_end) state_d = DISPLAY;
            end
            DISPLAY: begin
                scan_on[line_q] = 1'b1;
                if (disp_end) state_d = BLANK;
            end
            BLANK:   if (blank_end) state_d = (line_q == LINE_LAST) ? DONE : LOAD;
            DONE: begin
                O_frame_done = 1'b1;
                state_d      = start_req ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
        O_scan = (SCAN_ACT_LOW != 0) ? ~scan_on : scan_on;
    end

    assign DCLK       = dclk_q;
    assign GCLK       = gclk_q;
    assign O_line_idx = line_q;
    assign O_chan_idx = chan_q;

    // Timing counters; the divider is shared because SHIFT and DISPLAY never overlap.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            div_q   <= '0;
            bit_q   <= '0;
            le_q    <= '0;
            pulse_q <= '0;
            blank_q <= '0;
            dclk_q  <= 1'b0;
            gclk_q  <= 1'b0;
        end else begin
            if (state_q != state_d || (state_q != SHIFT && state_q != DISPLAY)) div_q <= '0;
            else                                                              div_q <= div_end ? '0 : div_q + 1'b1;

            if (state_q == SHIFT && div_end) dclk_q <= ~dclk_q;
            else if (state_q != SHIFT)       dclk_q <= 1'b0;

            if (state_q != SHIFT) bit_q <= '0;
            else if (shift_fall)  bit_q <= bit_q + 1'b1;

            le_q    <= (state_q == LATCH) ? le_q + 1'b1 : '0;
            blank_q <= (state_q == BLANK) ? blank_q + 1'b1 : '0;

            if (state_q == DISPLAY && div_end) gclk_q <= ~gclk_q;
            else if (state_q != DISPLAY)       gclk_q <= 1'b0;

            if (state_q != DISPLAY)                  pulse_q <= '0;
            else if (div_end && !gclk_q)             pulse_q <= pulse_q + 1'b1;
        end
    end

    // Line/channel indices and the single-level restart request.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            line_q    <= '0;
            chan_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            if ((state_q == IDLE || state_q == DONE) && state_d == LOAD) begin
                line_q <= '0;
                chan_q <= CHAN_LAST;
            end else if (word_end && chan_q != '0) begin
                chan_q <= chan_q - 1'b1;
            end else if (state_q == BLANK && state_d == LOAD) begin
                line_q <= line_q + 1'b1;
                chan_q <= CHAN_LAST;
            end

            if (state_q == DONE)             pending_q <= 1'b0;
            else if (I_frame_start && active) pending_q <= 1'b1;
        end
    end

    always_ff @(posedge I_clk) begin
        if (state_q == LOAD && I_data_valid) shreg <= I_data;
        else if (shift_fall)                 shreg <= {shreg[GRAY_BITS-2:0], 1'b0};
    end

endmodule

// File: tb/tb_miniled_scan_driver.sv
// Scoreboard bench for miniled_scan_driver: stimulus queues expected serial bits, scan windows and
// frame completions; a negedge monitor pops and compares them and checks pin invariants every cycle.
module tb_miniled_scan_driver;

    localparam int CHANNELS     = 2;
    localparam int GRAY_BITS    = 4;
    localparam int SCAN_LINES   = 2;
    localparam int CLK_DIV      = 1;
    localparam int LE_DCLKS     = 1;
    localparam int GCLK_PULSES  = 4;
    localparam int BLANK_CYCLES = 3;

    logic       I_clk = 1'b0;
    logic       I_rst;
    logic       I_frame_start;
    logic [3:0] I_data;
    logic       I_data_valid;
    logic       O_data_ready;
    logic [0:0] O_line_idx;
    logic [0:0] O_chan_idx;
    logic       SDI, DCLK, LE, GCLK;
    logic [1:0] O_scan;
    logic       O_busy, O_frame_done;

    logic [3:0] words [0:1][0:1];
    logic       feed, stall;

    assign I_data       = words[O_line_idx][O_chan_idx];
    assign I_data_valid = feed && !stall;

    miniled_scan_driver #(
        .CHANNELS(CHANNELS), .GRAY_BITS(GRAY_BITS), .SCAN_LINES(SCAN_LINES), .CLK_DIV(CLK_DIV),
        .LE_DCLKS(LE_DCLKS), .GCLK_PULSES(GCLK_PULSES), .BLANK_CYCLES(BLANK_CYCLES), .SCAN_ACT_LOW(1)
    ) dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_frame_start(I_frame_start), .I_data(I_data),
        .I_data_valid(I_data_valid), .O_data_ready(O_data_ready), .O_line_idx(O_line_idx),
        .O_chan_idx(O_chan_idx), .SDI(SDI), .DCLK(DCLK), .LE(LE), .GCLK(GCLK), .O_scan(O_scan),
        .O_busy(O_busy), .O_frame_done(O_frame_done)
    );

    always #5 I_clk = ~I_clk;

    int   checks = 0;
    int   errors = 0;
    bit   track = 1'b0;
    int   frame_no = 0;
    int   done_seen = 0;
    bit   sdi_exp[$];
    logic [1:0] win_exp[$];
    int   done_exp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected SDI stream: channel 1 word then channel 0 word, MSB first, line by line.
    task automatic push_frame();
        frame_no++;
        for (int l = 0; l < 2; l++) begin
            for (int c = 1; c >= 0; c--)
                for (int b = 3; b >= 0; b--) sdi_exp.push_back(words[l][c][b]);
            win_exp.push_back((l == 0) ? 2'b10 : 2'b01);
        end
        done_exp.push_back(frame_no);
    endtask

    task automatic pulse_start();
        I_frame_start = 1'b1;
        @(negedge I_clk);
        I_frame_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!O_frame_done && n < budget) begin
            @(negedge I_clk);
            n++;
        end
        if (!O_frame_done) check("frame_done_timeout", 0, 1);
    endtask

    logic prev_dclk = 1'b0, prev_sdi = 1'b0, prev_gclk = 1'b0;
    logic [1:0] prev_scan = 2'b11;
    int   gcnt = 0, le_w = 0, blank_run = 0;
    bit   in_blank = 1'b0;

    always @(negedge I_clk) begin
        if (I_rst) begin
            prev_dclk = 1'b0; prev_sdi = 1'b0; prev_gclk = 1'b0; prev_scan = 2'b11;
            gcnt = 0; le_w = 0; in_blank = 1'b0;
        end else begin
            check("scan_onehot", ($countones(~O_scan) <= 1), 1);
            check("le_exclusive", (LE && (DCLK || GCLK)), 0);
            if (prev_dclk && DCLK) check("sdi_stable", SDI, prev_sdi);
            if (track) begin
                if (DCLK && !prev_dclk) begin
                    if (sdi_exp.size() == 0) check("sdi_extra_bit", 1, 0);
                    else                     check("sdi_bit", SDI, sdi_exp.pop_front());
                end
                if (LE) le_w++;
                else if (le_w != 0) begin
                    check("le_width", le_w, 2);
                    le_w = 0;
                end
                if (in_blank) begin
                    if (O_data_ready || O_frame_done) begin
                        check("blank_len", blank_run, 3);
                        in_blank = 1'b0;
                    end else blank_run++;
                end
                if (O_scan != 2'b11) begin
                    if (prev_scan == 2'b11) gcnt = 0;
                    if (GCLK && !prev_gclk) gcnt++;
                end else if (prev_scan != 2'b11) begin
                    if (win_exp.size() == 0) check("scan_extra_window", 1, 0);
                    else                     check("scan_pattern", prev_scan, win_exp.pop_front());
                    check("gclk_rises", gcnt, 4);
                    check("gclk_low_at_end", GCLK, 0);
                    in_blank  = 1'b1;
                    blank_run = 1;
                end
                if (O_frame_done) begin
                    done_seen++;
                    check("done_busy_low", O_busy, 0);
                    if (done_exp.size() == 0) check("done_extra", 1, 0);
                    else                      check("done_seq", done_seen, done_exp.pop_front());
                end
            end
            prev_dclk = DCLK; prev_sdi = SDI; prev_gclk = GCLK; prev_scan = O_scan;
        end
    end

    initial begin
        int   n;
        int   activity;
        logic s0;
        I_rst = 1'b1; I_frame_start = 1'b0; feed = 1'b0; stall = 1'b0;
        words[0][0] = 4'h0; words[0][1] = 4'h0; words[1][0] = 4'h0; words[1][1] = 4'h0;
        repeat (2) @(negedge I_clk);
        check("rst_scan", O_scan, 2'b11);
        check("rst_sdi", SDI, 0);
        check("rst_dclk", DCLK, 0);
        check("rst_le", LE, 0);
        check("rst_gclk", GCLK, 0);
        check("rst_ready", O_data_ready, 0);
        check("rst_busy", O_busy, 0);
        check("rst_done", O_frame_done, 0);
        check("rst_line", O_line_idx, 0);
        check("rst_chan", O_chan_idx, 0);
        I_rst = 1'b0;

        // Reset asserted while a line is on display.
        feed = 1'b1;
        @(negedge I_clk);
        pulse_start();
        n = 0;
        while (O_scan == 2'b11 && n < 200) begin
            @(negedge I_clk);
            n++;
        end
        check("reach_display", (O_scan != 2'b11), 1);
        @(posedge I_clk);
        #2 I_rst = 1'b1;
        @(negedge I_clk);
        check("midrst_scan", O_scan, 2'b11);
        check("midrst_gclk", GCLK, 0);
        check("midrst_busy", O_busy, 0);
        check("midrst_le", LE, 0);
        @(negedge I_clk);
        I_rst = 1'b0;
        activity = 0;
        repeat (20) begin
            @(negedge I_clk);
            if (O_busy || DCLK || GCLK || LE || O_data_ready || O_scan != 2'b11) activity++;
        end
        check("idle_after_rst", activity, 0);

        // Frame 1: words always valid except a 10-cycle stall before line 0 channel 0.
        words[0][1] = 4'hA; words[0][0] = 4'h5; words[1][1] = 4'h3; words[1][0] = 4'hC;
        push_frame();
        track = 1'b1;
        pulse_start();
        n = 0;
        while (!(O_data_ready && O_line_idx == 0 && O_chan_idx == 0) && n < 100) begin
            @(negedge I_clk);
            n++;
        end
        check("reach_load_ch0", (O_data_ready && O_chan_idx == 0), 1);
        stall = 1'b1;
        s0 = SDI;
        repeat (10) begin
            @(negedge I_clk);
            check("stall_dclk", DCLK, 0);
            check("stall_sdi", SDI, s0);
            check("stall_ready", O_data_ready, 1);
        end
        stall = 1'b0;
        wait_done(400);
        @(negedge I_clk);
        check("frame1_idle", O_busy, 0);

        // Frame 2 with three merged restart requests: exactly one extra frame.
        words[0][1] = 4'h9; words[0][0] = 4'h6; words[1][1] = 4'hF; words[1][0] = 4'h1;
        push_frame();
        push_frame();
        pulse_start();
        repeat (5) @(negedge I_clk);
        pulse_start();
        @(negedge I_clk);
        pulse_start();
        repeat (20) @(negedge I_clk);
        pulse_start();
        wait_done(400);
        @(negedge I_clk);
        check("restart_busy", O_busy, 1);
        check("restart_ready", O_data_ready, 1);
        wait_done(400);
        @(negedge I_clk);
        check("after_extra_idle", O_busy, 0);
        repeat (100) @(negedge I_clk);
        check("stays_idle", O_busy, 0);
        check("frames_done", done_seen, 3);
        check("sdi_queue_empty", sdi_exp.size(), 0);
        check("win_queue_empty", win_exp.size(), 0);
        check("done_queue_empty", done_exp.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
